// File: rtl/clk_div_prog_if.sv
// clk_div_prog_if: control/status bundle of clk_div_prog; CLKDIV_SYNC_EN adds sync_in.
interface clk_div_prog_if #(parameter int WIDTH = 8);
  logic enable, load, load_ack, cfg_error, clock_output, rise_tick, fall_tick;
  logic [WIDTH-1:0] div_value, high_value;
`ifdef CLKDIV_SYNC_EN
  logic sync_in;
  modport master (output enable, load, div_value, high_value, sync_in,
                  input load_ack, cfg_error, clock_output, rise_tick, fall_tick);
  modport slave (input enable, load, div_value, high_value, sync_in,
                 output load_ack, cfg_error, clock_output, rise_tick, fall_tick);
`else
  modport master (output enable, load, div_value, high_value,
                  input load_ack, cfg_error, clock_output, rise_tick, fall_tick);
  modport slave (input enable, load, div_value, high_value,
                 output load_ack, cfg_error, clock_output, rise_tick, fall_tick);
`endif
endinterface

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with period/high-time reload at period boundaries; CLKDIV_SYNC_EN adds sync_in restart.
module clk_div_prog #(
  parameter int WIDTH = 8,
  parameter int DEFAULT_DIV = 4,
  parameter int DEFAULT_HIGH = 2
) (
  input logic clock_input,
  input logic reset,
  clk_div_prog_if.slave bus
);
  logic [WIDTH-1:0] cnt, div_act, high_act, pend_div, pend_high, cnt_next, high_next;
  logic pend, running, sync, valid, boundary, apply, out_next;
`ifdef CLKDIV_SYNC_EN
  assign sync = bus.sync_in;
`else
  assign sync = 1'b0;
`endif
  always_comb begin
    valid = bus.div_value >= WIDTH'(2) && bus.high_value != '0 && bus.high_value < bus.div_value;
    boundary = bus.enable && (sync || (running && cnt == div_act - WIDTH'(1)));
    apply = pend && (!bus.enable || boundary);
    cnt_next = (!bus.enable || !running || boundary) ? '0 : cnt + WIDTH'(1);
    high_next = apply ? pend_high : high_act;
    out_next = bus.enable && cnt_next < high_next;
  end
  always_ff @(posedge clock_input) begin
    if (!reset) begin
      cnt <= '0;
      running <= 1'b0;
      bus.clock_output <= 1'b0;
      bus.rise_tick <= 1'b0;
      bus.fall_tick <= 1'b0;
      bus.load_ack <= 1'b0;
      bus.cfg_error <= 1'b0;
      div_act <= WIDTH'(DEFAULT_DIV);
      high_act <= WIDTH'(DEFAULT_HIGH);
      pend <= 1'b0;
      pend_div <= '0;
      pend_high <= '0;
    end else begin
      cnt <= cnt_next;
      running <= bus.enable;
      bus.clock_output <= out_next;
      bus.rise_tick <= out_next & ~bus.clock_output;
      bus.fall_tick <= ~out_next & bus.clock_output;
      bus.load_ack <= apply;
      bus.cfg_error <= bus.load && !valid;
      if (apply) begin
        div_act <= pend_div;
        high_act <= pend_high;
      end
      pend <= (bus.load && valid) || (pend && !apply);
      if (bus.load && valid) begin
        pend_div <= bus.div_value;
        pend_high <= bus.high_value;
      end
    end
  end
endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed plus random stimulus checked each cycle against a period/phase reference model.
module tb_clk_div_prog;
  logic clk, reset;
  clk_div_prog_if #(.WIDTH(8)) bus ();
  clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(4), .DEFAULT_HIGH(2)) dut (
    .clock_input(clk),
    .reset(reset),
    .bus(bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  bit en, ld, sy;
  int dv, hv;
  bit m_run, m_pend, m_out, m_rise, m_fall, m_ack, m_err;
  int m_phase, m_div, m_high, m_pdiv, m_phigh;
  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got out/rise/fall/ack/err=%b, expected %b", tag, $time, got, exp);
    end
  endtask
  task automatic step(input string tag);
    bit prev, bd;
    @(posedge clk);
    prev = m_out;
    m_ack = 0;
    m_err = 0;
    if (!reset) begin
      m_run = 0; m_phase = 0; m_div = 4; m_high = 2; m_pend = 0; m_out = 0; prev = 0;
    end else begin
      bd = en && (sy || (m_run && m_phase == m_div - 1));
      if (m_pend && (!en || bd)) begin
        m_div = m_pdiv; m_high = m_phigh; m_pend = 0; m_ack = 1;
      end
      m_phase = (!en || !m_run || bd) ? 0 : m_phase + 1;
      m_run = en;
      m_out = en && (m_phase < m_high);
      if (ld) begin
        if (dv >= 2 && hv >= 1 && hv <= dv - 1) begin
          m_pdiv = dv; m_phigh = hv; m_pend = 1;
        end else m_err = 1;
      end
    end
    m_rise = m_out && !prev;
    m_fall = !m_out && prev;
    @(negedge clk);
    check(tag, {bus.clock_output, bus.rise_tick, bus.fall_tick, bus.load_ack, bus.cfg_error},
          {m_out, m_rise, m_fall, m_ack, m_err});
  endtask
  task automatic drive(input bit e, input bit l, input int d, input int h, input bit s);
    en = e; ld = l; dv = d; hv = h; sy = s;
    bus.enable = e;
    bus.load = l;
    bus.div_value = 8'(d);
    bus.high_value = 8'(h);
`ifdef CLKDIV_SYNC_EN
    bus.sync_in = s;
`endif
  endtask
  task automatic cyc(input string tag, input bit e, input bit l, input int d, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      drive(e, l && i == 0, d, h, 1'b0);
      step(tag);
    end
  endtask
  initial begin
    drive(0, 0, 0, 0, 0);
    reset = 1'b0;
    @(negedge clk);
    cyc("reset", 1, 1, 6, 3, 3);
    reset = 1'b1;
    cyc("default", 1, 0, 0, 0, 12);
    cyc("load5_1", 1, 1, 5, 1, 1);
    cyc("load5_1", 1, 0, 0, 0, 12);
    cyc("bad1_1", 1, 1, 1, 1, 3);
    cyc("bad6_6", 1, 1, 6, 6, 8);
    cyc("twoload", 1, 1, 6, 3, 1);
    cyc("twoload", 1, 1, 8, 4, 1);
    cyc("twoload", 1, 0, 0, 0, 16);
    for (int i = 0; i < 16 && !m_out; i++) cyc("seekhigh", 1, 0, 0, 0, 1);
    cyc("disable", 0, 0, 0, 0, 2);
    cyc("reenable", 1, 0, 0, 0, 10);
    cyc("pendrst", 1, 1, 3, 1, 2);
    reset = 1'b0;
    cyc("midrst", 1, 0, 0, 0, 1);
    reset = 1'b1;
    cyc("afterrst", 1, 0, 0, 0, 10);
`ifdef CLKDIV_SYNC_EN
    while (m_phase != 1) cyc("seeksync", 1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    step("sync");
    cyc("aftersync", 1, 0, 0, 0, 6);
`endif
    for (int i = 0; i < 800; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      drive($urandom_range(0, 15) != 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 12), $urandom_range(0, 12), $urandom_range(0, 19) == 0);
`ifndef CLKDIV_SYNC_EN
      sy = 1'b0;
`endif
      step("random");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule
